// File: rtl/branch_predictor.sv
`default_nettype none
// ============================================================================
//  Module      : branch_predictor
//  Description : Fetch-side direct-mapped predictor. Lookup of a 2-bit
//                saturating counter plus target buffer for the fetch PC
//                (combinational), trained by resolved branch/jump outcomes.
//                Flags mispredicts one cycle after the update and keeps
//                saturating update/mispredict statistics.
//  Revision    : 1.0 - initial release
// ============================================================================
module branch_predictor #(
    parameter int INDEX_BITS = 4,
    parameter int TAG_BITS   = 8,
    parameter int STAT_W     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       fetch_pc,
    output logic              pred_taken,
    output logic [31:0]       pred_target,
    input  logic              upd_valid,
    input  logic [31:0]       upd_pc,
    input  logic              upd_taken,
    input  logic              upd_is_jump,
    input  logic [31:0]       upd_target,
    input  logic              upd_pred_taken,
    output logic              mispredict,
    output logic [31:0]       redirect_pc,
    output logic [STAT_W-1:0] stat_branches,
    output logic [STAT_W-1:0] stat_mispred
);

    localparam int c_ENTRIES = 2 ** INDEX_BITS;
    localparam int c_IDX_HI  = INDEX_BITS + 1;
    localparam int c_TAG_LO  = INDEX_BITS + 2;
    localparam int c_TAG_HI  = INDEX_BITS + TAG_BITS + 1;

    // Prediction table
    logic                r_valid  [c_ENTRIES];
    logic [TAG_BITS-1:0] r_tag    [c_ENTRIES];
    logic [31:0]         r_target [c_ENTRIES];
    logic [1:0]          r_ctr    [c_ENTRIES];

    logic                r_mispredict;
    logic [31:0]         r_redirectPc;
    logic [STAT_W-1:0]   r_statBranches;
    logic [STAT_W-1:0]   r_statMispred;

    logic [INDEX_BITS-1:0] w_fetchIdx;
    logic [TAG_BITS-1:0]   w_fetchTag;
    logic                  w_fetchHit;
    logic [INDEX_BITS-1:0] w_updIdx;
    logic [TAG_BITS-1:0]   w_updTag;
    logic                  w_updHit;
    logic                  w_updWrite;
    logic [1:0]            w_ctrNext;
    logic                  w_mispredictNow;
    logic                  w_unusedFetchBits;

    assign w_fetchIdx = fetch_pc[c_IDX_HI:2];
    assign w_fetchTag = fetch_pc[c_TAG_HI:c_TAG_LO];
    assign w_updIdx   = upd_pc[c_IDX_HI:2];
    assign w_updTag   = upd_pc[c_TAG_HI:c_TAG_LO];

    // Byte-offset and high PC bits take no part in the lookup.
    assign w_unusedFetchBits = ^fetch_pc;

    // Lookup sees pre-edge table contents; there is no update bypass.
    assign w_fetchHit  = r_valid[w_fetchIdx] && (r_tag[w_fetchIdx] == w_fetchTag);
    assign pred_taken  = w_fetchHit & r_ctr[w_fetchIdx][1];
    assign pred_target = w_fetchHit ? r_target[w_fetchIdx] : 32'h0;

    assign w_updHit        = r_valid[w_updIdx] && (r_tag[w_updIdx] == w_updTag);
    assign w_updWrite      = upd_valid & (upd_taken | w_updHit);
    assign w_mispredictNow = upd_valid & (upd_taken != upd_pred_taken);

    // Next counter value for the entry being trained (saturating, never wraps)
    always_comb begin
        w_ctrNext = r_ctr[w_updIdx];
        if (upd_taken) begin
            if (upd_is_jump) begin
                w_ctrNext = 2'd3;
            end else if (w_updHit) begin
                w_ctrNext = (r_ctr[w_updIdx] == 2'd3) ? 2'd3 : r_ctr[w_updIdx] + 2'd1;
            end else begin
                w_ctrNext = 2'd2;
            end
        end else if (r_ctr[w_updIdx] != 2'd0) begin
            w_ctrNext = r_ctr[w_updIdx] - 2'd1;
        end
    end

    // Table training: taken allocates/refreshes, not-taken only decays a hit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < c_ENTRIES; i++) begin
                r_valid[i]  <= 1'b0;
                r_tag[i]    <= '0;
                r_target[i] <= 32'h0;
                r_ctr[i]    <= 2'b01;
            end
        end else if (w_updWrite) begin
            r_valid[w_updIdx] <= 1'b1;
            r_tag[w_updIdx]   <= w_updTag;
            r_ctr[w_updIdx]   <= w_ctrNext;
            if (upd_taken) begin
                r_target[w_updIdx] <= upd_target;
            end
        end
    end

    // Mispredict pulse and redirect PC; redirect holds between mispredicts
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mispredict <= 1'b0;
            r_redirectPc <= 32'h0;
        end else begin
            r_mispredict <= w_mispredictNow;
            if (w_mispredictNow) begin
                r_redirectPc <= upd_taken ? upd_target : upd_pc + 32'd4;
            end
        end
    end

    // Saturating statistics counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_statBranches <= '0;
            r_statMispred  <= '0;
        end else begin
            if (upd_valid && (r_statBranches != '1)) begin
                r_statBranches <= r_statBranches + 1'b1;
            end
            if (w_mispredictNow && (r_statMispred != '1)) begin
                r_statMispred <= r_statMispred + 1'b1;
            end
        end
    end

    assign mispredict    = r_mispredict;
    assign redirect_pc   = r_redirectPc;
    assign stat_branches = r_statBranches;
    assign stat_mispred  = r_statMispred;

endmodule
`default_nettype wire

// File: tb/tb_branch_predictor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_branch_predictor
//  Description : Self-checking bench for branch_predictor. Directed scenarios
//                with literal expectations, then randomized traffic compared
//                every cycle against a behavioural table model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_predictor;

    localparam int c_IB      = 4;
    localparam int c_TB      = 8;
    localparam int c_SW      = 8;
    localparam int c_ENT     = 1 << c_IB;
    localparam int c_STATMAX = (1 << c_SW) - 1;

    logic            clk;
    logic            rst_n;
    logic [31:0]     fetch_pc;
    logic            pred_taken;
    logic [31:0]     pred_target;
    logic            upd_valid;
    logic [31:0]     upd_pc;
    logic            upd_taken;
    logic            upd_is_jump;
    logic [31:0]     upd_target;
    logic            upd_pred_taken;
    logic            mispredict;
    logic [31:0]     redirect_pc;
    logic [c_SW-1:0] stat_branches;
    logic [c_SW-1:0] stat_mispred;

    branch_predictor #(
        .INDEX_BITS (c_IB),
        .TAG_BITS   (c_TB),
        .STAT_W     (c_SW)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fetch_pc       (fetch_pc),
        .pred_taken     (pred_taken),
        .pred_target    (pred_target),
        .upd_valid      (upd_valid),
        .upd_pc         (upd_pc),
        .upd_taken      (upd_taken),
        .upd_is_jump    (upd_is_jump),
        .upd_target     (upd_target),
        .upd_pred_taken (upd_pred_taken),
        .mispredict     (mispredict),
        .redirect_pc    (redirect_pc),
        .stat_branches  (stat_branches),
        .stat_mispred   (stat_mispred)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nChecks = 0;
    int nPass   = 0;
    bit checkEn = 1'b0;

    // Behavioural model: table of entries plus expected registered outputs
    bit          mValid  [c_ENT];
    int          mTag    [c_ENT];
    logic [31:0] mTarget [c_ENT];
    int          mCtr    [c_ENT];
    bit          expMis;
    logic [31:0] expRedir;
    int          expBr;
    int          expMp;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act === exp) nPass++;
        else $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    endtask

    function automatic int idxOf(input logic [31:0] pc);
        return int'((pc >> 2) % c_ENT);
    endfunction

    function automatic int tagOf(input logic [31:0] pc);
        return int'((pc >> (2 + c_IB)) % (1 << c_TB));
    endfunction

    task automatic modelReset();
        for (int i = 0; i < c_ENT; i++) begin
            mValid[i] = 1'b0; mTag[i] = 0; mTarget[i] = 32'h0; mCtr[i] = 1;
        end
        expMis = 1'b0; expRedir = 32'h0; expBr = 0; expMp = 0;
    endtask

    // Applies one clock edge worth of training to the model
    task automatic modelUpdate();
        int  idx;
        bit  hit;
        bit  mis;
        if (!rst_n) return;
        idx = idxOf(upd_pc);
        hit = mValid[idx] && (mTag[idx] == tagOf(upd_pc));
        if (!upd_valid) begin
            expMis = 1'b0;
            return;
        end
        if (upd_taken) begin
            if (upd_is_jump)  mCtr[idx] = 3;
            else if (hit)     mCtr[idx] = (mCtr[idx] + 1 > 3) ? 3 : mCtr[idx] + 1;
            else              mCtr[idx] = 2;
            mValid[idx]  = 1'b1;
            mTag[idx]    = tagOf(upd_pc);
            mTarget[idx] = upd_target;
        end else if (hit) begin
            mCtr[idx] = (mCtr[idx] - 1 < 0) ? 0 : mCtr[idx] - 1;
        end
        mis    = (upd_taken != upd_pred_taken);
        expMis = mis;
        if (mis) expRedir = upd_taken ? upd_target : upd_pc + 32'd4;
        expBr = (expBr == c_STATMAX) ? c_STATMAX : expBr + 1;
        if (mis) expMp = (expMp == c_STATMAX) ? c_STATMAX : expMp + 1;
    endtask

    task automatic cycle();
        @(posedge clk);
        modelUpdate();
        #1;
    endtask

    task automatic setUpd(input bit v, input logic [31:0] pc, input bit tk, input bit jmp,
                          input logic [31:0] tgt, input bit pr);
        upd_valid = v; upd_pc = pc; upd_taken = tk; upd_is_jump = jmp;
        upd_target = tgt; upd_pred_taken = pr;
    endtask

    // Per-cycle comparison of every DUT output against the model
    always @(negedge clk) begin
        if (checkEn) begin
            int  i;
            bit  hit;
            i   = idxOf(fetch_pc);
            hit = mValid[i] && (mTag[i] == tagOf(fetch_pc));
            chk("pred_taken",    32'(pred_taken),    32'(hit && (mCtr[i] >= 2)));
            chk("pred_target",   pred_target,        hit ? mTarget[i] : 32'h0);
            chk("mispredict",    32'(mispredict),    32'(expMis));
            chk("redirect_pc",   redirect_pc,        expRedir);
            chk("stat_branches", 32'(stat_branches), 32'(expBr));
            chk("stat_mispred",  32'(stat_mispred),  32'(expMp));
        end
    end

    function automatic logic [31:0] randPc();
        logic [31:0] pc;
        if ($urandom_range(0, 15) == 0) pc = $urandom;
        else pc = (32'($urandom_range(0, 3)) << (2 + c_IB)) | (32'($urandom_range(0, c_ENT - 1)) << 2);
        return pc;
    endfunction

    initial begin
        rst_n = 1'b0;
        fetch_pc = 32'h40;
        setUpd(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        modelReset();
        #2;
        // 1. reset state
        chk("rst_pred_taken",  32'(pred_taken),    32'h0);
        chk("rst_pred_target", pred_target,        32'h0);
        chk("rst_stat_br",     32'(stat_branches), 32'h0);
        chk("rst_stat_mp",     32'(stat_mispred),  32'h0);
        chk("rst_mispredict",  32'(mispredict),    32'h0);
        cycle();
        rst_n   = 1'b1;
        checkEn = 1'b1;

        // 2. taken allocation with mispredict
        setUpd(1'b1, 32'h40, 1'b1, 1'b0, 32'h20, 1'b0);
        cycle();
        setUpd(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        #1;
        chk("s2_mispredict",  32'(mispredict),   32'h1);
        chk("s2_redirect",    redirect_pc,       32'h20);
        chk("s2_stat_mp",     32'(stat_mispred), 32'h1);
        chk("s2_pred_taken",  32'(pred_taken),   32'h1);
        chk("s2_pred_target", pred_target,       32'h20);

        // 3. decay to zero without underflow wrap
        setUpd(1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 1'b1);
        repeat (3) cycle();
        setUpd(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        #1;
        chk("s3_pred_taken", 32'(pred_taken), 32'h0);
        chk("s3_mispredict", 32'(mispredict), 32'h1);
        setUpd(1'b1, 32'h40, 1'b1, 1'b0, 32'h20, 1'b0);
        cycle();
        setUpd(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        #1;
        chk("s3_no_wrap_taken",  32'(pred_taken), 32'h0);
        chk("s3_no_wrap_target", pred_target,     32'h20);

        // 4. jump allocation, same-index alias misses
        setUpd(1'b1, 32'h100, 1'b1, 1'b1, 32'h200, 1'b0);
        cycle();
        setUpd(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        fetch_pc = 32'h100; #1;
        chk("s4_jump_taken",  32'(pred_taken), 32'h1);
        chk("s4_jump_target", pred_target,     32'h200);
        fetch_pc = 32'h140; #1;
        chk("s4_alias_taken", 32'(pred_taken), 32'h0);
        fetch_pc = 32'h40; #1;
        chk("s4_evicted",     32'(pred_taken), 32'h0);

        // 5. not-taken mispredict redirects to fall-through
        setUpd(1'b1, 32'h80, 1'b0, 1'b0, 32'h0, 1'b1);
        cycle();
        #1;
        chk("s5_mispredict", 32'(mispredict), 32'h1);
        chk("s5_redirect",   redirect_pc,     32'h84);
        setUpd(1'b1, 32'h80, 1'b0, 1'b0, 32'h0, 1'b0);
        cycle();
        setUpd(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        #1;
        chk("s5_no_mispredict", 32'(mispredict),    32'h0);
        chk("s5_redirect_hold", redirect_pc,        32'h84);
        chk("s5_stat_br",       32'(stat_branches), 32'd8);
        chk("s5_stat_mp",       32'(stat_mispred),  32'd7);

        // 6. asynchronous reset during a mispredict pulse
        setUpd(1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 1'b1);
        cycle();
        setUpd(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        fetch_pc = 32'h100;
        chk("s6_pulse", 32'(mispredict), 32'h1);
        #1 rst_n = 1'b0;
        modelReset();
        #1;
        chk("s6_mispredict", 32'(mispredict),    32'h0);
        chk("s6_redirect",   redirect_pc,        32'h0);
        chk("s6_stat_br",    32'(stat_branches), 32'h0);
        chk("s6_pred_taken", 32'(pred_taken),    32'h0);
        chk("s6_pred_tgt",   pred_target,        32'h0);
        rst_n = 1'b1;
        cycle();

        // Randomized traffic; long reset-free stretches reach stat saturation
        for (int n = 0; n < 4000; n++) begin
            fetch_pc = randPc();
            setUpd(1'($urandom_range(0, 3) != 0), randPc(), 1'($urandom), 1'($urandom_range(0, 3) == 0),
                   $urandom, 1'($urandom));
            if ($urandom_range(0, 999) == 0) begin
                #1 rst_n = 1'b0;
                modelReset();
                #1 rst_n = 1'b1;
            end
            cycle();
        end

        checkEn = 1'b0;
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
`default_nettype wire
